axi4lite_regbank_slave: RTL and testbench
=========================================

# axi4lite_regbank_slave

AXI4-Lite slave register bank sitting directly downstream of the AXI4-Lite master in `axi4lite_top`. It accepts the master's AW/W/B and AR/R channels and holds 2^ADDR_WIDTH registers of DATA_WIDTH bits. The last address is a read-only write counter; all other addresses are read/write. Register contents are exported flat for the top-level to drive `uo_out`/`uio_out`.

## Interface
- ADDR_WIDTH, 2, register index width; register count N = 2^ADDR_WIDTH
- DATA_WIDTH, 8, register/data width; multiple of 8
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_awaddr  in  ADDR_WIDTH  write register index
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte-lane enables
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  ADDR_WIDTH  read register index
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  always 00 (OKAY)
- s_rvalid / s_rready  out / in  1  R handshake
- regs_out  out  N*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Reset (async assert): all registers 0, write counter 0, all held AW/W state cleared; s_bvalid, s_rvalid, s_bresp, s_rdata, s_rresp, every ready = 0. Mid-transaction reset aborts the transaction silently.
- `ready_en` flag: cleared by reset, set on the first rising edge after rst_n deasserts. All readys are gated by it.
- Write path: AW and W are accepted independently in either order.
  - s_awready = ready_en & ~aw_held & ~s_bvalid; s_wready = ready_en & ~w_held & ~s_bvalid.
  - An accepted beat is latched (aw_held/w_held) until its partner arrives.
  - Commit edge: the edge at which both address and data are available (held or handshaking that edge).
  - Commit to index < N-1: apply s_wstrb per byte lane. Response OKAY. Counter increments by 1 mod 2^DATA_WIDTH, including when wstrb = 0.
  - Commit to index N-1: no change to any register or counter. Response SLVERR.
  - At commit: s_bvalid=1 and s_bresp set; held flags cleared. s_bvalid holds, with s_bresp stable, until s_bvalid & s_bready.
- Read path: s_arready = ready_en & ~s_rvalid.
  - On AR handshake, s_rdata is captured from the selected register (index N-1 returns the counter). s_rvalid=1 and s_rresp=00.
  - s_rdata holds stable until s_rvalid & s_rready.
- Read and write paths are fully independent and may be active in the same cycle.

## Timing
- Write latency: AW and W handshaking on the same edge E gives the register update at E, and s_bvalid is high in the cycle after E.
- Split AW/W: commit occurs on the later handshake edge.
- After a B handshake at edge E, s_awready/s_wready are high in the cycle after E. Maximum write throughput is one write per 2 cycles with s_bready tied high.
- Read latency: AR handshake at edge E gives s_rvalid with data in the cycle after E. Throughput is one read per 2 cycles with s_rready high.
- AR handshake at the same edge as a write commit to the same index (or to the counter): the read returns the pre-write value.
- regs_out reflects register state directly; it updates in the cycle after the commit edge.
- Counter wraps 2^DATA_WIDTH-1 → 0.

## Structure
- Shared package `axi4lite_pkg` holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10 constants.
  - The 2-bit resp typedef. Shared with the master.
- One sub-module, `axi4lite_wr_join`, does the AW/W latching and produces commit, addr and data/strb. It has ready gating inputs (ready_en, s_bvalid) and clears on commit.
- The register array, counter, B logic and R logic stay in the top of this block.

## Test plan
- Reset then write: deassert rst_n. The first cycle after release must show all readys = 0. Write idx 2 data 0x04 with AW+W in the same cycle → bresp 00 in the next cycle, regs_out[23:16]=0x04. Read idx 2 → rdata 0x04, rresp 00. Read idx 3 → 0x01.
- Split order: W (0xA5, strb 1) three cycles before AW idx 0 → s_wready=0 while held. Commit occurs at the AW edge → reg0=0xA5, counter=1.
- Read-only target: write 0xFF to idx 3 → bresp 10. Counter and all registers unchanged.
- Backpressure: hold s_bready=0 for 5 cycles after commit → s_bvalid and s_bresp stable, awready/wready=0 throughout. Same check with s_rready=0 on a read: rdata stable and arready=0.
- Collision and wrap: preload the counter to 0xFF via 255 writes. Issue AR idx 3 on the same edge as the 256th write commit → rdata 0xFF, then a subsequent read → 0x00. Also check wstrb=0 to idx 1 → reg1 unchanged, bresp 00, counter increments.
- Reset mid-write: assert rst_n low after AW is accepted but before W arrives → all outputs 0 immediately, no register changes. After release, a fresh write completes normally.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions for the master and the register-bank slave.
// Response codes, response type and write-join state encoding.
package axi4lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      JOIN_IDLE = 2'd0,
      JOIN_AW   = 2'd1,
      JOIN_W    = 2'd2
   } join_state_t;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle between master and register-bank slave.
// Signal names follow the slave-side view.
interface axi4lite_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
);
   import axi4lite_pkg::*;

   logic [ADDR_WIDTH-1:0]   s_awaddr;
   logic                    s_awvalid;
   logic                    s_awready;
   logic [DATA_WIDTH-1:0]   s_wdata;
   logic [DATA_WIDTH/8-1:0] s_wstrb;
   logic                    s_wvalid;
   logic                    s_wready;
   resp_t                   s_bresp;
   logic                    s_bvalid;
   logic                    s_bready;
   logic [ADDR_WIDTH-1:0]   s_araddr;
   logic                    s_arvalid;
   logic                    s_arready;
   logic [DATA_WIDTH-1:0]   s_rdata;
   resp_t                   s_rresp;
   logic                    s_rvalid;
   logic                    s_rready;

   modport master (
      output s_awaddr, s_awvalid, input s_awready,
      output s_wdata, s_wstrb, s_wvalid, input s_wready,
      input s_bresp, s_bvalid, output s_bready,
      output s_araddr, s_arvalid, input s_arready,
      input s_rdata, s_rresp, s_rvalid, output s_rready
   );

   modport slave (
      input s_awaddr, s_awvalid, output s_awready,
      input s_wdata, s_wstrb, s_wvalid, output s_wready,
      output s_bresp, s_bvalid, input s_bready,
      input s_araddr, s_arvalid, output s_arready,
      output s_rdata, s_rresp, s_rvalid, input s_rready
   );

endinterface

// File: rtl/axi4lite_wr_join.sv
// Joins independently arriving AW and W beats into one write commit.
// A beat that arrives first is held until its partner shows up.
module axi4lite_wr_join
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ready_en,
   input  logic                    bvalid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic                    commit,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [DATA_WIDTH/8-1:0] strb
);

   join_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH/8-1:0] strb_q;

   logic aw_held, w_held, aw_hs, w_hs;

   assign aw_held = (state_q == JOIN_AW);
   assign w_held  = (state_q == JOIN_W);

   assign awready = ready_en & ~aw_held & ~bvalid;
   assign wready  = ready_en & ~w_held & ~bvalid;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   assign commit = (aw_held | aw_hs) & (w_held | w_hs);

   assign addr = aw_held ? addr_q : awaddr;
   assign data = w_held ? data_q : wdata;
   assign strb = w_held ? strb_q : wstrb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= JOIN_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         JOIN_IDLE: begin
            if (aw_hs && !w_hs)      state_d = JOIN_AW;
            else if (w_hs && !aw_hs) state_d = JOIN_W;
         end
         JOIN_AW: if (w_hs)  state_d = JOIN_IDLE;
         JOIN_W:  if (aw_hs) state_d = JOIN_IDLE;
         default: state_d = JOIN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else begin
         if (aw_hs) addr_q <= awaddr;
         if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
         end
      end
   end

endmodule

// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite slave register bank; the top index is a read-only write counter.
// Registers are exported flat on regs_out.
module axi4lite_regbank_slave
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   axi4lite_if.slave bus,
   output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] regs_out
);

   localparam int N  = 2**ADDR_WIDTH;
   localparam int NB = DATA_WIDTH/8;
   localparam logic [ADDR_WIDTH-1:0] RO_IDX = '1;

   logic                  ready_en;
   logic [DATA_WIDTH-1:0] regs [N];

   logic                  commit;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [NB-1:0]         w_strb;
   logic                  ro_hit;

   logic                  bvalid;
   resp_t                 bresp;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;
   resp_t                 rresp;
   logic                  arready;
   logic                  ar_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   axi4lite_wr_join #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_join (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready_en (ready_en),
      .bvalid   (bvalid),
      .awaddr   (bus.s_awaddr),
      .awvalid  (bus.s_awvalid),
      .awready  (bus.s_awready),
      .wdata    (bus.s_wdata),
      .wstrb    (bus.s_wstrb),
      .wvalid   (bus.s_wvalid),
      .wready   (bus.s_wready),
      .commit   (commit),
      .addr     (w_addr),
      .data     (w_data),
      .strb     (w_strb)
   );

   assign ro_hit = (w_addr == RO_IDX);

   // Counter lives in the top slot; writes aimed at it are rejected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) regs[i] <= '0;
      end else if (commit && !ro_hit) begin
         for (int i = 0; i < N-1; i++) begin
            if (w_addr == ADDR_WIDTH'(i)) begin
               for (int b = 0; b < NB; b++) begin
                  if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
               end
            end
         end
         regs[N-1] <= regs[N-1] + DATA_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid <= 1'b0;
         bresp  <= RESP_OKAY;
      end else if (commit) begin
         bvalid <= 1'b1;
         bresp  <= ro_hit ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bus.s_bready) begin
         bvalid <= 1'b0;
      end
   end

   assign arready = ready_en & ~rvalid;
   assign ar_hs   = bus.s_arvalid & arready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= regs[bus.s_araddr];
         rresp  <= RESP_OKAY;
      end else if (rvalid && bus.s_rready) begin
         rvalid <= 1'b0;
      end
   end

   assign bus.s_bvalid  = bvalid;
   assign bus.s_bresp   = bresp;
   assign bus.s_arready = arready;
   assign bus.s_rvalid  = rvalid;
   assign bus.s_rdata   = rdata;
   assign bus.s_rresp   = rresp;

   always_comb begin
      regs_out = '0;
      for (int i = 0; i < N; i++) regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
   end

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Directed bench for axi4lite_regbank_slave with immediate-assertion checks.
// Counter values below are tracked by hand across the whole sequence.
module tb_axi4lite_regbank_slave;
   import axi4lite_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] regs_out;
   int          n_cmp;
   int          n_err;
   logic [7:0]  rd;

   axi4lite_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

   axi4lite_regbank_slave #(
      .ADDR_WIDTH (2),
      .DATA_WIDTH (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .regs_out (regs_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input string tag, input logic [1:0] a,
                           input logic [7:0] d, input logic s,
                           input logic [1:0] exp_resp);
      int t;
      bus.s_awaddr  = a;
      bus.s_wdata   = d;
      bus.s_wstrb   = s;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      bus.s_bready  = 1'b1;
      t = 0;
      while (!(bus.s_awready && bus.s_wready) && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) check({tag, "_wtimeout"}, 32'd0, 32'd1);
      tick();
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      check({tag, "_bvalid"}, {31'd0, bus.s_bvalid}, 32'd1);
      check({tag, "_bresp"}, {30'd0, bus.s_bresp}, {30'd0, exp_resp});
      tick();
   endtask

   task automatic do_read(input string tag, input logic [1:0] a,
                          input logic [7:0] exp);
      int t;
      bus.s_araddr  = a;
      bus.s_arvalid = 1'b1;
      bus.s_rready  = 1'b1;
      t = 0;
      while (!bus.s_arready && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) check({tag, "_rtimeout"}, 32'd0, 32'd1);
      tick();
      bus.s_arvalid = 1'b0;
      check({tag, "_rvalid"}, {31'd0, bus.s_rvalid}, 32'd1);
      check({tag, "_rdata"}, {24'd0, bus.s_rdata}, {24'd0, exp});
      check({tag, "_rresp"}, {30'd0, bus.s_rresp}, 32'd0);
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_awready"}, {31'd0, bus.s_awready}, 32'd0);
      check({tag, "_wready"}, {31'd0, bus.s_wready}, 32'd0);
      check({tag, "_arready"}, {31'd0, bus.s_arready}, 32'd0);
      check({tag, "_bvalid"}, {31'd0, bus.s_bvalid}, 32'd0);
      check({tag, "_rvalid"}, {31'd0, bus.s_rvalid}, 32'd0);
      check({tag, "_bresp"}, {30'd0, bus.s_bresp}, 32'd0);
      check({tag, "_rdata"}, {24'd0, bus.s_rdata}, 32'd0);
      check({tag, "_rresp"}, {30'd0, bus.s_rresp}, 32'd0);
      check({tag, "_regs"}, regs_out, 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.s_awaddr  = '0;
      bus.s_awvalid = 1'b0;
      bus.s_wdata   = '0;
      bus.s_wstrb   = '0;
      bus.s_wvalid  = 1'b0;
      bus.s_bready  = 1'b1;
      bus.s_araddr  = '0;
      bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b1;

      // Reset state and first cycle after release
      tick();
      tick();
      check_idle_outputs("rst");
      rst_n = 1'b1;
      #1;
      check("rel_awready", {31'd0, bus.s_awready}, 32'd0);
      check("rel_wready", {31'd0, bus.s_wready}, 32'd0);
      check("rel_arready", {31'd0, bus.s_arready}, 32'd0);
      tick();
      check("en_awready", {31'd0, bus.s_awready}, 32'd1);
      check("en_arready", {31'd0, bus.s_arready}, 32'd1);

      // Simultaneous AW+W write, then read back
      bus.s_awaddr  = 2'd2;
      bus.s_wdata   = 8'h04;
      bus.s_wstrb   = 1'b1;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      check("w1_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
      check("w1_bresp", {30'd0, bus.s_bresp}, 32'd0);
      check("w1_reg2", {24'd0, regs_out[23:16]}, 32'h04);
      check("w1_awready_busy", {31'd0, bus.s_awready}, 32'd0);
      tick();
      check("w1_bdone", {31'd0, bus.s_bvalid}, 32'd0);
      check("w1_awready_back", {31'd0, bus.s_awready}, 32'd1);
      do_read("r1_idx2", 2'd2, 8'h04);
      do_read("r1_idx3", 2'd3, 8'h01);

      // W three cycles ahead of AW
      bus.s_wdata  = 8'hA5;
      bus.s_wstrb  = 1'b1;
      bus.s_wvalid = 1'b1;
      tick();
      bus.s_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("split_wready_held", {31'd0, bus.s_wready}, 32'd0);
         check("split_awready", {31'd0, bus.s_awready}, 32'd1);
         check("split_noreg", {24'd0, regs_out[7:0]}, 32'h00);
         if (i < 2) tick();
      end
      bus.s_awaddr  = 2'd0;
      bus.s_awvalid = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      check("split_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
      check("split_reg0", {24'd0, regs_out[7:0]}, 32'hA5);
      check("split_cnt", {24'd0, regs_out[31:24]}, 32'h02);
      tick();

      // Write to the read-only counter slot
      do_write("ro", 2'd3, 8'hFF, 1'b1, RESP_SLVERR);
      check("ro_regs", regs_out, 32'h0204_00A5);

      // B backpressure
      bus.s_bready  = 1'b0;
      bus.s_awaddr  = 2'd1;
      bus.s_wdata   = 8'h5A;
      bus.s_wstrb   = 1'b1;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
         check("bp_bresp", {30'd0, bus.s_bresp}, 32'd0);
         check("bp_awready", {31'd0, bus.s_awready}, 32'd0);
         check("bp_wready", {31'd0, bus.s_wready}, 32'd0);
         tick();
      end
      bus.s_bready = 1'b1;
      tick();
      check("bp_bdone", {31'd0, bus.s_bvalid}, 32'd0);
      check("bp_regs", regs_out, 32'h0304_5AA5);

      // R backpressure
      bus.s_rready  = 1'b0;
      bus.s_araddr  = 2'd0;
      bus.s_arvalid = 1'b1;
      tick();
      bus.s_arvalid = 1'b0;
      bus.s_araddr  = 2'd1;
      for (int i = 0; i < 5; i++) begin
         check("rbp_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
         check("rbp_rdata", {24'd0, bus.s_rdata}, 32'hA5);
         check("rbp_arready", {31'd0, bus.s_arready}, 32'd0);
         tick();
      end
      bus.s_rready = 1'b1;
      tick();
      check("rbp_rdone", {31'd0, bus.s_rvalid}, 32'd0);

      // Zero strobe still counts
      do_write("strb0", 2'd1, 8'hFF, 1'b0, RESP_OKAY);
      check("strb0_regs", regs_out, 32'h0404_5AA5);

      // Bring counter from 4 to 0xFF
      for (int i = 0; i < 251; i++) begin
         do_write("fill", 2'd0, 8'(i), 1'b1, RESP_OKAY);
      end
      check("fill_regs", regs_out, 32'hFF04_5AFA);

      // AR to counter on the same edge as the wrapping commit
      bus.s_awaddr  = 2'd2;
      bus.s_wdata   = 8'h77;
      bus.s_wstrb   = 1'b1;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      bus.s_araddr  = 2'd3;
      bus.s_arvalid = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      bus.s_arvalid = 1'b0;
      check("col_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
      check("col_rdata", {24'd0, bus.s_rdata}, 32'hFF);
      check("col_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
      check("col_bresp", {30'd0, bus.s_bresp}, 32'd0);
      tick();
      do_read("wrap_cnt", 2'd3, 8'h00);
      do_read("col_reg2", 2'd2, 8'h77);

      // Reset while AW is held waiting for W
      bus.s_awaddr  = 2'd1;
      bus.s_awvalid = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      check("mid_awheld", {31'd0, bus.s_awready}, 32'd0);
      check("mid_wready", {31'd0, bus.s_wready}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_regs", regs_out, 32'h0000_0000);
      do_write("post", 2'd1, 8'h3C, 1'b1, RESP_OKAY);
      check("post_regs2", regs_out, 32'h0100_3C00);
      do_read("post_rd", 2'd1, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
